// File: rtl/regbus_read_sequencer.sv
// rtl/regbus_read_sequencer.sv - tri-state register bus reader: select, settle, capture, turnaround
// Optional scan of all registers is compiled in with macro REGBUS_READ_SCAN_EN.
module regbus_read_sequencer #(
  parameter int NrOfBits     = 32,
  parameter int NrOfRegs     = 4,
  parameter int AddrBits     = 2,
  parameter int SettleCycles = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                Start,
  input  logic                Scan,
  input  logic [AddrBits-1:0] Addr,
  input  logic [NrOfBits-1:0] BusIn,
  output logic [NrOfRegs-1:0] Cs,
  output logic                Busy,
  output logic                Valid,
  output logic [NrOfBits-1:0] DataOut,
  output logic [AddrBits-1:0] AddrOut,
  output logic                Error
);

  typedef enum logic [1:0] {IDLE, SELECT, TURN} state_t;

  localparam logic [3:0]          SettleInit = 4'(SettleCycles);
  localparam logic [AddrBits-1:0] LastAddr   = AddrBits'(NrOfRegs - 1);
  localparam logic [31:0]         NrRegs32   = NrOfRegs;

  state_t              state, state_next;
  logic [3:0]          cnt, cnt_next;
  logic [AddrBits-1:0] addr_q, addr_next, addr_inc;
  logic                scan_q, scan_next, scan_req;
  logic                addr_in_range;
  logic [NrOfRegs-1:0] cs_next;
  logic                busy_next, valid_next, error_next;
  logic [NrOfBits-1:0] data_next;
  logic [AddrBits-1:0] addrout_next;

  // Low bit at idx selects that register; every other register floats.
  function automatic logic [NrOfRegs-1:0] select_mask(input logic [AddrBits-1:0] idx);
    select_mask = ~({{(NrOfRegs-1){1'b0}}, 1'b1} << idx);
  endfunction

  assign addr_in_range = ({{(32-AddrBits){1'b0}}, Addr} < NrRegs32);
  assign addr_inc      = addr_q + AddrBits'(1);

`ifdef REGBUS_READ_SCAN_EN
  assign scan_req = Scan;
`else
  // Without the scan feature every Start is a single read.
  logic unused_scan;
  assign unused_scan = Scan;
  assign scan_req    = 1'b0;
`endif

  // Next-state and next-output logic; everything holds unless Tick advances it.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    addr_next    = addr_q;
    scan_next    = scan_q;
    cs_next      = Cs;
    busy_next    = Busy;
    valid_next   = 1'b0;
    data_next    = DataOut;
    addrout_next = AddrOut;
    error_next   = Error;
    if (Tick) begin
      case (state)
        IDLE: begin
          if (Start) begin
            if (scan_req) begin
              error_next = 1'b0;
              scan_next  = 1'b1;
              addr_next  = '0;
              cs_next    = select_mask('0);
              busy_next  = 1'b1;
              cnt_next   = SettleInit;
              state_next = SELECT;
            end else if (!addr_in_range) begin
              error_next = 1'b1;
            end else begin
              error_next = 1'b0;
              scan_next  = 1'b0;
              addr_next  = Addr;
              cs_next    = select_mask(Addr);
              busy_next  = 1'b1;
              cnt_next   = SettleInit;
              state_next = SELECT;
            end
          end
        end
        SELECT: begin
          if (cnt == 4'd1) begin
            data_next    = BusIn;
            addrout_next = addr_q;
            valid_next   = 1'b1;
            cs_next      = '1;
            state_next   = TURN;
          end else begin
            cnt_next = cnt - 4'd1;
          end
        end
        TURN: begin
          // Cs was released on the capture edge; one full Tick-cycle of float
          // separates this register from the next driver.
          cs_next = '1;
          if (scan_q && (addr_q != LastAddr)) begin
            addr_next  = addr_inc;
            cs_next    = select_mask(addr_inc);
            cnt_next   = SettleInit;
            state_next = SELECT;
          end else begin
            busy_next  = 1'b0;
            scan_next  = 1'b0;
            state_next = IDLE;
          end
        end
        default: begin
          cs_next    = '1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      endcase
    end
  end

  // State and registered outputs; synchronous reset wins over everything.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      scan_q  <= 1'b0;
      Cs      <= '1;
      Busy    <= 1'b0;
      Valid   <= 1'b0;
      DataOut <= '0;
      AddrOut <= '0;
      Error   <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      addr_q  <= addr_next;
      scan_q  <= scan_next;
      Cs      <= cs_next;
      Busy    <= busy_next;
      Valid   <= valid_next;
      DataOut <= data_next;
      AddrOut <= addrout_next;
      Error   <= error_next;
    end
  end

endmodule

// File: tb/tb_regbus_read_sequencer.sv
// tb/tb_regbus_read_sequencer.sv - self-checking bench for regbus_read_sequencer
module tb_regbus_read_sequencer;

  localparam int NB = 32;
  localparam int NR = 4;
  localparam int AB = 2;
  localparam int SC = 2;

  logic          Clock = 1'b0;
  logic          Reset, Tick, Start, Scan;
  logic [AB-1:0] Addr;
  logic [NB-1:0] BusIn;
  logic [NR-1:0] Cs;
  logic          Busy, Valid, Error;
  logic [NB-1:0] DataOut;
  logic [AB-1:0] AddrOut;

  logic          Start3;
  logic [AB-1:0] Addr3;
  logic [NB-1:0] BusIn3;
  logic [2:0]    Cs3;
  logic          Busy3, Valid3, Error3;
  logic [NB-1:0] DataOut3;
  logic [AB-1:0] AddrOut3;

  logic [NB-1:0] reg_val [NR];
  logic [NB-1:0] reg3_val [3];

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  always #5 Clock = ~Clock;

  regbus_read_sequencer #(.NrOfBits(NB), .NrOfRegs(NR), .AddrBits(AB), .SettleCycles(SC)) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .Start(Start), .Scan(Scan), .Addr(Addr),
    .BusIn(BusIn), .Cs(Cs), .Busy(Busy), .Valid(Valid), .DataOut(DataOut),
    .AddrOut(AddrOut), .Error(Error)
  );

  regbus_read_sequencer #(.NrOfBits(NB), .NrOfRegs(3), .AddrBits(AB), .SettleCycles(SC)) dut3 (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .Start(Start3), .Scan(Scan), .Addr(Addr3),
    .BusIn(BusIn3), .Cs(Cs3), .Busy(Busy3), .Valid(Valid3), .DataOut(DataOut3),
    .AddrOut(AddrOut3), .Error(Error3)
  );

  // Bus: the selected register drives, nobody selected (or a clash) gives X.
  always_comb begin
    BusIn = 'x;
    case (Cs)
      4'b1110: BusIn = reg_val[0];
      4'b1101: BusIn = reg_val[1];
      4'b1011: BusIn = reg_val[2];
      4'b0111: BusIn = reg_val[3];
      default: BusIn = 'x;
    endcase
  end

  always_comb begin
    BusIn3 = 'x;
    case (Cs3)
      3'b110:  BusIn3 = reg3_val[0];
      3'b101:  BusIn3 = reg3_val[1];
      3'b011:  BusIn3 = reg3_val[2];
      default: BusIn3 = 'x;
    endcase
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Timeline model: an accepted request becomes a list of Tick-cycle slots,
  // each naming the Cs pattern shown during it; one slot is consumed per Tick.
  typedef struct {
    logic [3:0] cs;
    bit         cap;
    int         a;
  } slot_t;

  slot_t         q[$];
  logic [3:0]    m_cs    = 4'b1111;
  logic          m_busy  = 1'b0;
  logic          m_valid = 1'b0;
  logic          m_err   = 1'b0;
  logic [NB-1:0] m_data  = '0;
  logic [AB-1:0] m_addr  = '0;

  function automatic void push_read(input int a);
    for (int k = 0; k < SC; k++)
      q.push_back('{cs: ~(4'b0001 << a), cap: (k == SC - 1), a: a});
    q.push_back('{cs: 4'b1111, cap: 1'b0, a: 0});
  endfunction

  always @(posedge Clock) begin
    slot_t s;
    m_valid = 1'b0;
    if (Reset) begin
      q.delete();
      m_cs = 4'b1111; m_busy = 1'b0; m_err = 1'b0; m_data = '0; m_addr = '0;
    end else if (Tick) begin
      if (q.size() == 0) begin
        if (Start) begin
`ifdef REGBUS_READ_SCAN_EN
          if (Scan) begin
            m_err = 1'b0;
            for (int a = 0; a < NR; a++) push_read(a);
          end else
`endif
          if (int'(Addr) >= NR) m_err = 1'b1;
          else begin
            m_err = 1'b0;
            push_read(int'(Addr));
          end
        end
      end else begin
        s = q.pop_front();
        if (s.cap) begin
          m_valid = 1'b1;
          m_data  = reg_val[s.a];
          m_addr  = AB'(s.a);
        end
      end
      m_cs   = (q.size() != 0) ? q[0].cs : 4'b1111;
      m_busy = (q.size() != 0);
    end
  end

  // Per-cycle comparison of the main instance against the model.
  always @(negedge Clock) begin
    if (chk_en) begin
      check("cyc_cs", Cs, m_cs);
      check("cyc_busy", Busy, m_busy);
      check("cyc_valid", Valid, m_valid);
      check("cyc_error", Error, m_err);
      check("cyc_dataout", DataOut, m_data);
      check("cyc_addrout", AddrOut, m_addr);
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int vcnt, vedge, bcnt, ccnt;
    logic [31:0] vaddr [$];
    logic [31:0] vdata [$];

    Reset = 1'b1; Tick = 1'b1; Start = 1'b0; Scan = 1'b0; Addr = '0;
    Start3 = 1'b0; Addr3 = '0;
    reg_val[0] = 32'hA0A0_0000; reg_val[1] = 32'h1111_2222;
    reg_val[2] = 32'hDEAD_BEEF; reg_val[3] = 32'h3333_4444;
    reg3_val[0] = 32'hCAFE_0000; reg3_val[1] = 32'hCAFE_0001; reg3_val[2] = 32'hCAFE_0002;

    // 1: reset values, Start ignored under reset
    repeat (2) step();
    chk_en = 1'b1;
    check("rst_cs", Cs, 4'b1111);
    check("rst_busy", Busy, 0);
    check("rst_valid", Valid, 0);
    check("rst_dataout", DataOut, 0);
    check("rst_addrout", AddrOut, 0);
    check("rst_error", Error, 0);
    Start = 1'b1; Addr = 2'd2;
    step();
    check("rst_start_busy", Busy, 0);
    check("rst_start_cs", Cs, 4'b1111);

    // 2: single read of register 2, Tick always high
    Reset = 1'b0;
    step();                                   // edge 0
    Start = 1'b0; Addr = 2'd1;
    check("s2_cs_e0", Cs, 4'b1011);
    check("s2_model_cs_e0", m_cs, 4'b1011);
    check("s2_busy_e0", Busy, 1);
    step();                                   // edge 1
    check("s2_cs_e1", Cs, 4'b1011);
    check("s2_valid_e1", Valid, 0);
    step();                                   // edge 2
    check("s2_valid_e2", Valid, 1);
    check("s2_data_e2", DataOut, 32'hDEAD_BEEF);
    check("s2_model_data_e2", m_data, 32'hDEAD_BEEF);
    check("s2_addr_e2", AddrOut, 2);
    check("s2_cs_e2", Cs, 4'b1111);
    check("s2_busy_e2", Busy, 1);
    step();                                   // edge 3
    check("s2_busy_e3", Busy, 0);
    check("s2_model_busy_e3", m_busy, 0);
    check("s2_valid_e3", Valid, 0);

    // 3: same read with Tick every third cycle
    vcnt = 0; vedge = -1;
    for (int c = 0; c < 12; c++) begin
      Tick = (c % 3 == 0);
      Start = (c == 0);
      Addr = 2'd2;
      step();
      if (Valid === 1'b1) begin vcnt++; vedge = c; end
    end
    Tick = 1'b1; Start = 1'b0;
    check("s3_valid_width", vcnt, 1);
    check("s3_valid_edge", vedge, 6);
    check("s3_data", DataOut, 32'hDEAD_BEEF);
    check("s3_busy_end", Busy, 0);

    // 5: reset in the second SELECT cycle; Start while busy ignored
    Start = 1'b1; Addr = 2'd1;
    step();                                   // edge 0, select reg 1
    Addr = 2'd3;
    step();                                   // edge 1, Start ignored
    check("s5_ignored_cs", Cs, 4'b1101);
    Start = 1'b0; Reset = 1'b1;
    step();                                   // edge 2, reset instead of capture
    check("s5_rst_cs", Cs, 4'b1111);
    check("s5_rst_valid", Valid, 0);
    check("s5_rst_busy", Busy, 0);
    Reset = 1'b0;
    vcnt = 0;
    repeat (4) begin
      step();
      if (Valid !== 1'b0) vcnt++;
    end
    check("s5_no_valid", vcnt, 0);

    // 4: three-register instance, out-of-range then normal read
    Start3 = 1'b1; Addr3 = 2'd3;
    step();
    check("s4_err_set", Error3, 1);
    check("s4_err_cs", Cs3, 3'b111);
    check("s4_err_busy", Busy3, 0);
    check("s4_err_valid", Valid3, 0);
    Addr3 = 2'd0;
    step();
    Start3 = 1'b0;
    check("s4_err_clr", Error3, 0);
    check("s4_cs", Cs3, 3'b110);
    check("s4_busy", Busy3, 1);
    step();
    step();
    check("s4_valid", Valid3, 1);
    check("s4_data", DataOut3, 32'hCAFE_0000);
    check("s4_addr", AddrOut3, 0);
    step();
    check("s4_done", Busy3, 0);

    // 6: scan request (single read of Addr when scan is not built in)
    reg_val[0] = 32'h11; reg_val[1] = 32'h22; reg_val[2] = 32'h33; reg_val[3] = 32'h44;
    Start = 1'b1; Scan = 1'b1; Addr = 2'd2;
    bcnt = 0; ccnt = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      Start = 1'b0; Scan = 1'b0;
      if (Busy === 1'b1) bcnt++;
      if (Busy === 1'b1 && Cs === 4'b1111) ccnt++;
      if (Valid === 1'b1) begin
        vaddr.push_back(32'(AddrOut));
        vdata.push_back(DataOut);
      end
    end
`ifdef REGBUS_READ_SCAN_EN
    check("s6_pulses", vaddr.size(), 4);
    check("s6_busy_cycles", bcnt, 12);
    check("s6_turn_cycles", ccnt, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < vaddr.size()) begin
        check("s6_addr", vaddr[i], i);
        check("s6_data", vdata[i], 32'h11 * (i + 1));
      end
    end
`else
    check("s6_pulses", vaddr.size(), 1);
    check("s6_busy_cycles", bcnt, 3);
    check("s6_turn_cycles", ccnt, 1);
    if (vaddr.size() > 0) begin
      check("s6_addr", vaddr[0], 2);
      check("s6_data", vdata[0], 32'h33);
    end
`endif
    check("s6_busy_end", Busy, 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
